// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM states, frame size and
// baud-divider helpers.
package uart_pkg;

    localparam int unsigned FRAME_BITS = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } uartState_t;

    // Clock cycles per serial bit.
    function automatic int unsigned calcDiv(input int unsigned clkFreq, input int unsigned uartBps);
        return clkFreq / uartBps;
    endfunction

    // Cycles from the start-bit edge to its centre.
    function automatic int unsigned calcHalf(input int unsigned div);
        return div / 2;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic one-bit two-flop synchronizer for asynchronous inputs.
module sync_2ff #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic asyncIn,
    output logic syncOut
);

    logic metaStage;

    // Two-stage capture; both stages return to the line's idle level on reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            metaStage <= RESET_VALUE;
            syncOut   <= RESET_VALUE;
        end else begin
            metaStage <= asyncIn;
            syncOut   <= metaStage;
        end
    end

endmodule

// File: rtl/uart_rx_deserializer.sv
// 8N1 UART receiver: recovers frames from the PC RX line, emits each good byte
// with a one-cycle valid strobe and flags bad stop bits.
module uart_rx_deserializer
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 100_000_000,
    parameter int unsigned UART_BPS = 128000
) (
    input  logic       iFpgaClock,
    input  logic       iCpuReset,
    input  logic       iUartFromPc,
    output logic [7:0] oByte,
    output logic       oByteValid,
    output logic       oFrameError,
    output logic       oBusy
);

    localparam int unsigned DIV   = calcDiv(CLK_FREQ, UART_BPS);
    localparam int unsigned HALF  = calcHalf(DIV);
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [2:0]       LAST_BIT = 3'(FRAME_BITS - 1);

    logic                  rxSync;
    uartState_t            state, stateNext;
    logic [CNT_W-1:0]      cnt, cntNext;
    logic [2:0]            bitIdx, bitIdxNext;
    logic [FRAME_BITS-1:0] shift, shiftNext;
    logic [7:0]            byteNext;
    logic                  validNext;
    logic                  errorNext;

    sync_2ff #(
        .RESET_VALUE(1'b1)
    ) rxSyncInst (
        .clock  (iFpgaClock),
        .reset  (iCpuReset),
        .asyncIn(iUartFromPc),
        .syncOut(rxSync)
    );

    // State, datapath and output registers; reset wins over everything.
    always_ff @(posedge iFpgaClock) begin
        if (iCpuReset) begin
            state       <= IDLE;
            cnt         <= '0;
            bitIdx      <= '0;
            shift       <= '0;
            oByte       <= '0;
            oByteValid  <= 1'b0;
            oFrameError <= 1'b0;
        end else begin
            state       <= stateNext;
            cnt         <= cntNext;
            bitIdx      <= bitIdxNext;
            shift       <= shiftNext;
            oByte       <= byteNext;
            oByteValid  <= validNext;
            oFrameError <= errorNext;
        end
    end

    // Next-state and datapath: sample start at half a bit, then every full bit.
    always_comb begin
        stateNext  = state;
        cntNext    = cnt + 1'b1;
        bitIdxNext = bitIdx;
        shiftNext  = shift;
        byteNext   = oByte;
        validNext  = 1'b0;
        errorNext  = 1'b0;

        case (state)
            IDLE: begin
                cntNext = '0;
                if (!rxSync) begin
                    stateNext = START;
                end
            end
            START: begin
                if (cnt == CNT_HALF) begin
                    cntNext = '0;
                    if (!rxSync) begin
                        stateNext  = DATA;
                        bitIdxNext = '0;
                    end else begin
                        stateNext = IDLE;
                    end
                end
            end
            DATA: begin
                if (cnt == CNT_LAST) begin
                    cntNext   = '0;
                    shiftNext = {rxSync, shift[FRAME_BITS-1:1]};
                    if (bitIdx == LAST_BIT) begin
                        stateNext = STOP;
                    end else begin
                        bitIdxNext = bitIdx + 3'd1;
                    end
                end
            end
            STOP: begin
                if (cnt == CNT_LAST) begin
                    cntNext = '0;
                    if (rxSync) begin
                        byteNext  = shift;
                        validNext = 1'b1;
                        stateNext = IDLE;
                    end else begin
                        errorNext = 1'b1;
                        stateNext = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                cntNext = '0;
                if (rxSync) begin
                    stateNext = IDLE;
                end
            end
            default: begin
                cntNext   = '0;
                stateNext = IDLE;
            end
        endcase
    end

    // Busy covers the whole frame up to the stop-bit sample.
    always_comb begin
        oBusy = (state == START) || (state == DATA) || (state == STOP);
    end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Scoreboard bench for uart_rx_deserializer: a driver serialises frames and
// queues the expected pulse; a monitor pops and compares on every pulse.
module tb_uart_rx_deserializer;

    localparam int unsigned CLK_FREQ = 10_000_000;
    localparam int unsigned UART_BPS = 128_000;
    localparam int unsigned DIV      = CLK_FREQ / UART_BPS;
    localparam int unsigned HALF     = DIV / 2;
    localparam longint      LATENCY  = 3 + HALF + 9 * DIV;

    typedef struct {
        bit         isErr;
        logic [7:0] data;
        longint     when;
    } expEvent_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] oByte;
    logic       oByteValid;
    logic       oFrameError;
    logic       oBusy;

    longint     cyc = 0;
    int         passCnt = 0;
    int         totalCnt = 0;
    int         pulseCnt = 0;
    int         busyCycles = 0;
    bit         prevPulse = 1'b0;
    logic [7:0] lastGood = 8'h00;
    expEvent_t  expQ[$];

    uart_rx_deserializer #(
        .CLK_FREQ(CLK_FREQ),
        .UART_BPS(UART_BPS)
    ) dut (
        .iFpgaClock (clk),
        .iCpuReset  (rst),
        .iUartFromPc(rx),
        .oByte      (oByte),
        .oByteValid (oByteValid),
        .oFrameError(oFrameError),
        .oBusy      (oBusy)
    );

    always #5 clk = ~clk;

    // Edge index: after posedge N, cyc == N.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        totalCnt++;
        if (act == req) passCnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Monitor: compare each output pulse against the head of the queue.
    always @(negedge clk) begin
        if (oBusy === 1'b1) busyCycles++;
        if (oByteValid === 1'b1 || oFrameError === 1'b1) begin
            pulseCnt++;
            check("pulse_exclusive", longint'(oByteValid & oFrameError), 0);
            check("pulse_width", longint'(prevPulse), 0);
            if (expQ.size() == 0) begin
                totalCnt++;
                $display("FAIL unexpected_pulse: valid=%b error=%b byte=0x%h with no frame pending (cycle %0d)",
                         oByteValid, oFrameError, oByte, cyc);
            end else begin
                expEvent_t e;
                e = expQ.pop_front();
                check("pulse_kind_error", longint'(oFrameError), longint'(e.isErr));
                check("pulse_cycle", cyc, e.when);
                if (!e.isErr) begin
                    check("rx_byte", longint'(oByte), longint'(e.data));
                    lastGood = e.data;
                end else begin
                    check("byte_held_on_error", longint'(oByte), longint'(lastGood));
                end
            end
            prevPulse = 1'b1;
        end else begin
            prevPulse = 1'b0;
        end
    end

    task automatic hold(input logic lvl, input int unsigned n);
        rx = lvl;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Full frame; the expected pulse lands LATENCY edges after the start bit is captured.
    task automatic sendFrame(input logic [7:0] b, input bit stopHigh);
        expEvent_t e;
        e.isErr = !stopHigh;
        e.data  = b;
        e.when  = cyc + 1 + LATENCY;
        expQ.push_back(e);
        hold(1'b0, DIV);
        for (int i = 0; i < 8; i++) hold(b[i], DIV);
        hold(stopHigh, DIV);
    endtask

    initial begin
        int         p0;
        int         b0;
        logic [7:0] partial;
        logic [7:0] rb;
        bit         bad;

        // Reset with the line idle.
        rst = 1'b1;
        rx  = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_byte", longint'(oByte), 0);
        check("reset_valid", longint'(oByteValid), 0);
        check("reset_error", longint'(oFrameError), 0);
        check("reset_busy", longint'(oBusy), 0);
        @(posedge clk);
        #1;

        p0 = pulseCnt;
        hold(1'b1, 20000);
        check("idle_pulses", pulseCnt, p0);

        // Single byte.
        p0 = pulseCnt;
        sendFrame(8'hA5, 1'b1);
        hold(1'b1, 5);
        check("single_byte", longint'(oByte), 8'hA5);
        check("single_pulse_count", pulseCnt - p0, 1);

        // Back-to-back frames, no idle time between them.
        p0 = pulseCnt;
        sendFrame(8'h00, 1'b1);
        sendFrame(8'hFF, 1'b1);
        sendFrame(8'h3C, 1'b1);
        hold(1'b1, DIV);
        check("b2b_pulse_count", pulseCnt - p0, 3);

        // Glitch shorter than half a bit.
        p0 = pulseCnt;
        b0 = busyCycles;
        hold(1'b0, HALF / 3);
        hold(1'b1, 2 * DIV);
        check("glitch_busy_cycles", busyCycles - b0, HALF + 1);
        check("glitch_busy_after", longint'(oBusy), 0);
        check("glitch_pulses", pulseCnt - p0, 0);

        // Framing error followed by a break, then a good frame.
        p0 = pulseCnt;
        sendFrame(8'h5A, 1'b0);
        hold(1'b0, 3000);
        check("break_busy", longint'(oBusy), 0);
        check("break_pulse_count", pulseCnt - p0, 1);
        check("break_byte_held", longint'(oByte), 8'h3C);
        hold(1'b1, DIV);
        sendFrame(8'h3C, 1'b1);
        hold(1'b1, DIV);
        check("after_error_byte", longint'(oByte), 8'h3C);

        // Reset during data bit 4 of 0x81.
        p0 = pulseCnt;
        partial = 8'h81;
        hold(1'b0, DIV);
        for (int i = 0; i < 4; i++) hold(partial[i], DIV);
        hold(partial[4], DIV / 2);
        rst = 1'b1;
        lastGood = 8'h00;
        hold(1'b1, 3);
        rst = 1'b0;
        hold(1'b1, 2 * DIV);
        check("midreset_pulses", pulseCnt - p0, 0);
        check("midreset_byte", longint'(oByte), 0);
        check("midreset_busy", longint'(oBusy), 0);
        p0 = pulseCnt;
        sendFrame(8'h42, 1'b1);
        hold(1'b1, DIV);
        check("post_reset_byte", longint'(oByte), 8'h42);
        check("post_reset_pulse_count", pulseCnt - p0, 1);

        // Random frames with random gaps and occasional bad stop bits.
        for (int n = 0; n < 12; n++) begin
            rb  = 8'($urandom_range(0, 255));
            bad = ($urandom_range(0, 4) == 0);
            sendFrame(rb, !bad);
            if (bad) begin
                hold(1'b0, $urandom_range(0, 2 * DIV));
                hold(1'b1, DIV + $urandom_range(0, DIV));
            end else begin
                hold(1'b1, $urandom_range(0, 2 * DIV));
            end
        end

        for (int k = 0; k < 4 * DIV && expQ.size() != 0; k++) @(posedge clk);
        check("pending_expectations", expQ.size(), 0);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
